// File: rtl/gx_sched_pkg.sv
// gx_sched_pkg
//  Shared types and constants for the altgx cycle scheduler.
//  - state encoding for the scheduler FSM
//  - request word layout {seq, word_idx}
//  - datapath widths (tx word, sequence number, word index, window timer)
package gx_sched_pkg;

  localparam int TX_DATA_W = 16;
  localparam int SEQ_W     = 8;
  localparam int IDX_W     = 8;
  localparam int TMR_W     = 9;

  typedef logic [1:0] state_t;
  localparam state_t IDLE       = 2'd0;
  localparam state_t WAIT_PULSE = 2'd1;
  localparam state_t TX         = 2'd2;
  localparam state_t RX_WAIT    = 2'd3;

  // Request word as it appears on tx_data.
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [IDX_W-1:0] idx;
  } tx_word_t;

endpackage

// File: rtl/gx_cycle_scheduler_if.sv
// gx_cycle_scheduler_if
//  Link between the cycle scheduler and the altgx TX/RX adapters.
//  master (scheduler): drives tx_valid/tx_data/tx_last and rx_window,
//                      samples tx_ready, rx_valid, rx_last.
//  slave  (adapters) : the mirror image.
interface gx_cycle_scheduler_if;
  import gx_sched_pkg::*;

  logic                 tx_valid;
  logic                 tx_ready;
  logic [TX_DATA_W-1:0] tx_data;
  logic                 tx_last;
  logic                 rx_valid;
  logic                 rx_last;
  logic                 rx_window;

  modport master (
    output tx_valid, tx_data, tx_last, rx_window,
    input  tx_ready, rx_valid, rx_last
  );

  modport slave (
    input  tx_valid, tx_data, tx_last, rx_window,
    output tx_ready, rx_valid, rx_last
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter
//  Saturating up-counter for status reporting.
//  clk  in  clock
//  rst  in  async reset, active low
//  inc  in  count one event
//  clr  in  synchronous clear; beats a same-cycle inc
//  q    out count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    q <= '0;
    else if (clr)                q <= '0;
    else if (inc && (q != '1))   q <= q + W'(1);
  end

endmodule

// File: rtl/gx_cycle_scheduler.sv
// gx_cycle_scheduler
//  Runs one altgx transfer per cycle_pulse: a TX_WORDS-word request frame,
//  then a bounded receive window for the reply. Reports per-frame ok/timeout
//  strobes and saturating ok/timeout/overrun counters.
//  Ports
//   clk, rst          clock, async active-low reset
//   enable            run bit (level); low forces IDLE and freezes bookkeeping
//   cycle_pulse       1-clk frame start strobe
//   stat_clr          1-clk strobe, zeros the three counters
//   gx                tx/rx link (master side)
//   frame_ok/tmo      1-clk result strobes
//   ok/tmo/ovr_cnt    saturating status counters
//  Every output comes from a register; nothing is combinational from an input.
module gx_cycle_scheduler
  import gx_sched_pkg::*;
#(
  parameter int TX_WORDS   = 4,
  parameter int RX_TIMEOUT = 300,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cycle_pulse,
  input  logic             stat_clr,
  gx_cycle_scheduler_if.master gx,
  output logic             frame_ok,
  output logic             frame_tmo,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] tmo_cnt,
  output logic [CNT_W-1:0] ovr_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TX_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(RX_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [SEQ_W-1:0] seq;
  logic [TMR_W-1:0] timer;

  logic tx_valid_c, tx_last_c, rx_window_c;
  logic tx_hs, ok_evt, tmo_evt, ovr_evt;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       state_nxt = WAIT_PULSE;
        WAIT_PULSE: if (cycle_pulse)        state_nxt = TX;
        TX:         if (tx_hs && tx_last_c) state_nxt = RX_WAIT;
        RX_WAIT:    if (ok_evt || tmo_evt)  state_nxt = WAIT_PULSE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs / events
  // Link outputs decode the registered state only. The event terms mix in
  // inputs but are only consumed by registers (strobes, counters, FSM).
  always_comb begin
    tx_valid_c  = (state == TX);
    rx_window_c = (state == RX_WAIT);
    tx_last_c   = tx_valid_c && (idx == LAST_IDX);
    tx_hs       = enable && tx_valid_c && gx.tx_ready;
    ok_evt      = enable && rx_window_c && gx.rx_valid && gx.rx_last;
    // A reply landing on the expiry cycle takes precedence over the timeout.
    tmo_evt     = enable && rx_window_c && !ok_evt && (timer == TMR_END);
    // Pulses while busy are dropped, including the one that coincides with
    // the RX_WAIT exit: a new frame only starts from WAIT_PULSE.
    ovr_evt     = enable && cycle_pulse && (state == TX || state == RX_WAIT);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      seq       <= '0;
      timer     <= '0;
      frame_ok  <= 1'b0;
      frame_tmo <= 1'b0;
    end else begin
      frame_ok  <= ok_evt;
      frame_tmo <= tmo_evt;

      // Outside TX the index parks at 0, so an abandoned frame restarts at word 0.
      if (state != TX)  idx <= '0;
      else if (tx_hs)   idx <= idx + IDX_W'(1);

      if (tx_hs && tx_last_c) seq <= seq + SEQ_W'(1);

      if (state != RX_WAIT) timer <= '0;
      else                  timer <= timer + TMR_W'(1);
    end
  end

  tx_word_t tx_w;
  assign tx_w = '{seq: seq, idx: idx};

  assign gx.tx_valid  = tx_valid_c;
  assign gx.tx_last   = tx_last_c;
  assign gx.tx_data   = tx_w;
  assign gx.rx_window = rx_window_c;

  // ---------------------------------------------------------------- status counters
  sat_counter #(.W(CNT_W)) u_ok_cnt (
    .clk(clk), .rst(rst), .inc(ok_evt),  .clr(stat_clr), .q(ok_cnt)
  );

  sat_counter #(.W(CNT_W)) u_tmo_cnt (
    .clk(clk), .rst(rst), .inc(tmo_evt), .clr(stat_clr), .q(tmo_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ovr_cnt (
    .clk(clk), .rst(rst), .inc(ovr_evt), .clr(stat_clr), .q(ovr_cnt)
  );

endmodule

// File: tb/tb_gx_cycle_scheduler.sv
// tb_gx_cycle_scheduler
//  Scoreboard bench: expected request words and frame results are queued as
//  stimulus is driven and popped by a negedge monitor as the DUT emits them.
//  Counters are built 4 bits wide so saturation is reachable in a few frames.
module tb_gx_cycle_scheduler;
  import gx_sched_pkg::*;

  localparam int TX_WORDS   = 4;
  localparam int RX_TIMEOUT = 300;
  localparam int CNT_W      = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic cycle_pulse = 1'b0;
  logic stat_clr = 1'b0;
  logic frame_ok, frame_tmo;
  logic [CNT_W-1:0] ok_cnt, tmo_cnt, ovr_cnt;

  gx_cycle_scheduler_if bus();

  gx_cycle_scheduler #(
    .TX_WORDS(TX_WORDS), .RX_TIMEOUT(RX_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cycle_pulse(cycle_pulse),
    .stat_clr(stat_clr), .gx(bus), .frame_ok(frame_ok), .frame_tmo(frame_tmo),
    .ok_cnt(ok_cnt), .tmo_cnt(tmo_cnt), .ovr_cnt(ovr_cnt)
  );

  always #4 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;

  logic [16:0] exp_tx[$];   // {tx_last, seq, idx}
  logic [1:0]  exp_ev[$];   // {tmo, ok}
  logic [7:0]  exp_seq = 8'd0;

  logic        prev_stall = 1'b0;
  logic [16:0] prev_word  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (prev_stall)
      chk("tx_hold", 32'({bus.tx_valid, bus.tx_last, bus.tx_data}), 32'({1'b1, prev_word}));
    prev_stall = bus.tx_valid && !bus.tx_ready && enable;
    prev_word  = {bus.tx_last, bus.tx_data};

    if (bus.tx_valid && bus.tx_ready) begin
      hs_cnt++;
      if (exp_tx.size() == 0) chk("tx_q_nonempty", 32'(exp_tx.size()), 32'd1);
      else chk("tx_word", 32'({bus.tx_last, bus.tx_data}), 32'(exp_tx.pop_front()));
    end

    if (frame_ok || frame_tmo) begin
      if (exp_ev.size() == 0) chk("ev_q_nonempty", 32'(exp_ev.size()), 32'd1);
      else chk("frame_ev", 32'({frame_tmo, frame_ok}), 32'(exp_ev.pop_front()));
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse();
    cycle_pulse = 1'b1; tick(); cycle_pulse = 1'b0;
  endtask

  task automatic reply();
    bus.rx_valid = 1'b1; bus.rx_last = 1'b1; tick();
    bus.rx_valid = 1'b0; bus.rx_last = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < TX_WORDS; i++)
      exp_tx.push_back({(i == TX_WORDS - 1), exp_seq, 8'(i)});
  endtask

  task automatic wait_win();
    int n = 0;
    while (!bus.rx_window && n < 64) begin tick(); n++; end
    chk("win_wait", 32'(bus.rx_window), 32'd1);
  endtask

  task automatic ok_frame(input int dly);
    push_frame(); exp_ev.push_back(2'b01);
    bus.tx_ready = 1'b1;
    pulse(); wait_win();
    repeat (dly) tick();
    reply();
    exp_seq++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int hs0, n;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_last = 1'b0;

    repeat (3) @(posedge clk); #1;
    chk("rst_link", 32'({bus.tx_valid, bus.tx_last, bus.rx_window, bus.tx_data}), 32'd0);
    chk("rst_evt", 32'({frame_ok, frame_tmo}), 32'd0);
    chk("rst_cnt", 32'({ok_cnt, tmo_cnt, ovr_cnt}), 32'd0);
    rst = 1'b1;
    tick();

    // Pulse while disabled, then pulse on the IDLE->WAIT_PULSE cycle: both ignored.
    pulse();
    enable = 1'b1; pulse();
    tick();
    chk("idle_pulse_txv", 32'(bus.tx_valid), 32'd0);
    chk("idle_pulse_ovr", 32'(ovr_cnt), 32'd0);

    // 1: basic frame, reply at timer 10.
    push_frame(); exp_ev.push_back(2'b01);
    bus.tx_ready = 1'b1;
    pulse();
    chk("t1_lat_valid", 32'(bus.tx_valid), 32'd1);
    chk("t1_lat_data", 32'(bus.tx_data), 32'h0000);
    wait_win();
    repeat (10) tick();
    reply();
    chk("t1_ok", 32'(frame_ok), 32'd1);
    chk("t1_ok_cnt", 32'(ok_cnt), 32'd1);
    exp_seq++;

    // 2: stall three cycles on idx 1; rx words without last are ignored.
    hs0 = hs_cnt;
    push_frame(); exp_ev.push_back(2'b01);
    pulse();
    tick();
    bus.tx_ready = 1'b0;
    repeat (3) tick();
    chk("t2_hold_data", 32'(bus.tx_data), 32'h0101);
    bus.tx_ready = 1'b1;
    wait_win();
    chk("t2_handshakes", 32'(hs_cnt - hs0), 32'd4);
    bus.rx_valid = 1'b1; bus.rx_last = 1'b0;
    repeat (2) tick();
    bus.rx_valid = 1'b0;
    chk("t2_rx_nolast", 32'({bus.rx_window, frame_ok}), 32'b10);
    reply();
    chk("t2_ok_cnt", 32'(ok_cnt), 32'd2);
    exp_seq++;

    // 3: no reply -> timeout 300 clk after rx_window rises.
    push_frame(); exp_ev.push_back(2'b10);
    pulse(); wait_win();
    n = 0;
    while (!frame_tmo && n < 400) begin tick(); n++; end
    chk("t3_tmo_latency", 32'(n), 32'(RX_TIMEOUT));
    chk("t3_tmo_cnt", 32'(tmo_cnt), 32'd1);
    chk("t3_win_closed", 32'(bus.rx_window), 32'd0);
    exp_seq++;

    // Reply on the expiry cycle: success wins.
    push_frame(); exp_ev.push_back(2'b01);
    pulse(); wait_win();
    repeat (RX_TIMEOUT - 1) tick();
    reply();
    chk("exp_cycle_evt", 32'({frame_tmo, frame_ok}), 32'b01);
    chk("exp_cycle_cnts", 32'({ok_cnt, tmo_cnt}), 32'h31);
    exp_seq++;

    // 4: pulses during TX, during RX_WAIT and on the completion cycle.
    hs0 = hs_cnt;
    push_frame(); exp_ev.push_back(2'b01);
    bus.tx_ready = 1'b0;
    pulse();
    pulse();
    chk("t4_ovr_tx", 32'(ovr_cnt), 32'd1);
    bus.tx_ready = 1'b1;
    wait_win();
    pulse();
    chk("t4_ovr_rx", 32'(ovr_cnt), 32'd2);
    bus.rx_valid = 1'b1; bus.rx_last = 1'b1; cycle_pulse = 1'b1;
    tick();
    bus.rx_valid = 1'b0; bus.rx_last = 1'b0; cycle_pulse = 1'b0;
    chk("t4_ok", 32'(frame_ok), 32'd1);
    chk("t4_ovr_done", 32'(ovr_cnt), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_chain", 32'(bus.tx_valid), 32'd0);
      tick();
    end
    chk("t4_handshakes", 32'(hs_cnt - hs0), 32'd4);
    exp_seq++;

    // 5: drop enable with idx 2 on the bus.
    push_frame();
    pulse(); tick(); tick();
    chk("t5_idx2", 32'(bus.tx_data), 32'h0502);
    enable = 1'b0; bus.tx_ready = 1'b0;
    tick();
    chk("t5_txv_off", 32'(bus.tx_valid), 32'd0);
    chk("t5_abandoned", 32'(exp_tx.size()), 32'd2);
    exp_tx.delete();
    pulse();
    chk("t5_cnts", 32'({ok_cnt, tmo_cnt, ovr_cnt}), 32'h413);
    chk("t5_txv_idle", 32'(bus.tx_valid), 32'd0);
    enable = 1'b1; tick();
    ok_frame(3);   // same seq, restarts at word 0
    chk("t5_ok_cnt", 32'(ok_cnt), 32'd5);

    // 6: clear, saturate, clear colliding with an increment.
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    chk("t6_clr", 32'({ok_cnt, tmo_cnt, ovr_cnt}), 32'd0);
    repeat (15) ok_frame(0);
    chk("t6_full", 32'(ok_cnt), 32'hF);
    ok_frame(0);
    chk("t6_sat", 32'(ok_cnt), 32'hF);
    push_frame(); exp_ev.push_back(2'b01);
    pulse(); wait_win();
    stat_clr = 1'b1; reply(); stat_clr = 1'b0;
    exp_seq++;
    chk("t6_clr_inc_ok", 32'(frame_ok), 32'd1);
    chk("t6_clr_inc_cnt", 32'(ok_cnt), 32'd0);

    repeat (3) tick();
    chk("tx_q_drained", 32'(exp_tx.size()), 32'd0);
    chk("ev_q_drained", 32'(exp_ev.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
